// File: rtl/common_timer_seq_if.sv
// Control/status bundle for the multi-channel bring-up timer.
// The slave side is the timer; the master side is whoever sequences it.
interface common_timer_seq_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic                      i_restart;
  logic                      i_hold;
  logic [NUM_CH*CNT_W-1:0]   i_delay;
  logic                      o_tick;
  logic [NUM_CH-1:0]         o_start;
  logic                      o_done;

  modport master (
    output i_restart, i_hold, i_delay,
    input  o_tick, o_start, o_done
  );

  modport slave (
    input  i_restart, i_hold, i_delay,
    output o_tick, o_start, o_done
  );
endinterface

// File: rtl/common_timer_seq.sv
// Shared-prescaler start timer: NUM_CH channel counters fire start strobes
// after per-channel tick delays, in level, single-pulse or periodic mode.
module common_timer_seq #(
  parameter int MHZ     = 50,
  parameter int TICK_US = 1000,
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int MODE    = 0
) (
  input  logic                clk,
  input  logic                rst,
  common_timer_seq_if.slave   bus
);
  localparam int TICK_CYC = MHZ * TICK_US;
  localparam int PW       = $clog2(TICK_CYC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYC - 1);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [PW-1:0]     r_presc;
  logic [NUM_CH-1:0] r_fired, r_start;
  logic              r_done;
  logic [NUM_CH-1:0] w_fire, w_en, w_fired_next;
  logic              w_tick, w_all_fired;

  assign w_tick       = (r_state == S_RUN) && !bus.i_hold && (r_presc == PRESC_MAX);
  assign w_fired_next = r_fired | w_fire;
  // A disabled channel (zero delay) counts as already fired.
  assign w_all_fired  = &(w_fired_next | ~w_en);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_dly;
      logic [CNT_W-1:0] r_cnt;

      assign w_en[gi]   = (r_dly != '0);
      assign w_fire[gi] = w_tick && (r_cnt == CNT_W'(1));

      always_ff @(posedge clk) begin
        if (rst) begin
          r_dly <= '0;
          r_cnt <= '0;
        end else if (!bus.i_restart) begin
          if (r_state == S_LOAD) begin
            r_dly <= bus.i_delay[gi*CNT_W +: CNT_W];
            r_cnt <= bus.i_delay[gi*CNT_W +: CNT_W];
          end else if (w_tick && (r_cnt != '0)) begin
            // Periodic mode reloads on the firing tick; otherwise stop at zero.
            if ((MODE == 2) && (r_cnt == CNT_W'(1)))
              r_cnt <= r_dly;
            else
              r_cnt <= r_cnt - CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:  w_state_next = S_RUN;
      S_RUN:   if (w_all_fired && (MODE != 2)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_LOAD;
    endcase
    if (bus.i_restart) w_state_next = S_LOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_presc <= '0;
      r_fired <= '0;
      r_start <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (bus.i_restart) begin
        r_presc <= '0;
        r_fired <= '0;
        r_start <= '0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            r_presc <= '0;
            r_fired <= '0;
          end
          S_RUN: begin
            if (!bus.i_hold)
              r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
            r_fired <= w_fired_next;
            r_start <= (MODE == 0) ? (r_start | w_fire) : w_fire;
            if (w_all_fired) r_done <= 1'b1;
          end
          S_DONE: begin
            if (MODE != 0) r_start <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_tick  = w_tick;
  assign bus.o_start = r_start;
  assign bus.o_done  = r_done;
endmodule

// File: tb/tb_common_timer_seq.sv
// Directed bench: three timers (modes 0/1/2, TICK_CYC=4) against a tick-count model
// plus hand-computed cycle expectations.
module tb_common_timer_seq;
  localparam int T   = 4;
  localparam int NCH = 4;
  localparam int CW  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tb_restart = 1'b0;
  logic        tb_hold = 1'b0;
  logic [63:0] tb_delay = '0;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  common_timer_seq_if #(.NUM_CH(NCH), .CNT_W(CW)) if0 ();
  common_timer_seq_if #(.NUM_CH(NCH), .CNT_W(CW)) if1 ();
  common_timer_seq_if #(.NUM_CH(NCH), .CNT_W(CW)) if2 ();

  assign if0.i_restart = tb_restart;
  assign if1.i_restart = tb_restart;
  assign if2.i_restart = tb_restart;
  assign if0.i_hold    = tb_hold;
  assign if1.i_hold    = tb_hold;
  assign if2.i_hold    = tb_hold;
  assign if0.i_delay   = tb_delay;
  assign if1.i_delay   = tb_delay;
  assign if2.i_delay   = tb_delay;

  common_timer_seq #(.MHZ(4), .TICK_US(1), .NUM_CH(NCH), .CNT_W(CW), .MODE(0))
    u_m0 (.clk(clk), .rst(rst), .bus(if0));
  common_timer_seq #(.MHZ(4), .TICK_US(1), .NUM_CH(NCH), .CNT_W(CW), .MODE(1))
    u_m1 (.clk(clk), .rst(rst), .bus(if1));
  common_timer_seq #(.MHZ(4), .TICK_US(1), .NUM_CH(NCH), .CNT_W(CW), .MODE(2))
    u_m2 (.clk(clk), .rst(rst), .bus(if2));

  logic       dut_tick  [3];
  logic [3:0] dut_start [3];
  logic       dut_done  [3];
  assign dut_tick[0] = if0.o_tick;  assign dut_start[0] = if0.o_start;  assign dut_done[0] = if0.o_done;
  assign dut_tick[1] = if1.o_tick;  assign dut_start[1] = if1.o_start;  assign dut_done[1] = if1.o_done;
  assign dut_tick[2] = if2.o_tick;  assign dut_start[2] = if2.o_start;  assign dut_done[2] = if2.o_done;

  // Model: phase 0=load, 1=run, 2=stopped; a channel fires when the tick
  // count since load reaches its delay (or any multiple of it, periodic mode).
  int         m_phase [3];
  int         m_pre   [3];
  int         m_ticks [3];
  int         m_dly   [3][4];
  logic [3:0] m_fired [3];
  logic [3:0] m_start [3];
  logic       m_done  [3];
  bit         m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic rs, input logic h, input logic [63:0] dl);
    logic [3:0] fire;
    logic [3:0] en;
    bit         tk;
    for (int d = 0; d < 3; d++) begin
      fire = '0;
      en   = '0;
      if (r) begin
        m_phase[d] = 0; m_pre[d] = 0; m_ticks[d] = 0;
        m_fired[d] = '0; m_start[d] = '0; m_done[d] = 1'b0;
      end else if (rs) begin
        m_phase[d] = 0; m_pre[d] = 0; m_start[d] = '0; m_done[d] = 1'b0;
      end else if (m_phase[d] == 0) begin
        for (int k = 0; k < 4; k++) m_dly[d][k] = int'(dl[k*16 +: 16]);
        m_ticks[d] = 0; m_fired[d] = '0; m_pre[d] = 0; m_phase[d] = 1;
      end else if (m_phase[d] == 1) begin
        tk = !h && (m_pre[d] == T - 1);
        if (!h) m_pre[d] = (m_pre[d] + 1) % T;
        if (tk) begin
          m_ticks[d]++;
          for (int k = 0; k < 4; k++)
            if (m_dly[d][k] != 0)
              if ((d == 2) ? (m_ticks[d] % m_dly[d][k] == 0) : (m_ticks[d] == m_dly[d][k]))
                fire[k] = 1'b1;
        end
        for (int k = 0; k < 4; k++) en[k] = (m_dly[d][k] != 0);
        m_fired[d] = m_fired[d] | fire;
        m_start[d] = (d == 0) ? (m_start[d] | fire) : fire;
        if ((m_fired[d] | ~en) == 4'hF) begin
          m_done[d] = 1'b1;
          if (d != 2) m_phase[d] = 2;
        end
      end else if (d != 0) begin
        m_start[d] = '0;
      end
    end
    if (r) m_valid = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(rst, tb_restart, tb_hold, tb_delay);
      @(negedge clk);
      #2;
      if (m_valid) begin
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("mdl d%0d tick c%0d", d, cyc), int'(dut_tick[d]),
              int'((m_phase[d] == 1) && !tb_hold && (m_pre[d] == T - 1)));
          chk($sformatf("mdl d%0d start c%0d", d, cyc), int'(dut_start[d]), int'(m_start[d]));
          chk($sformatf("mdl d%0d done c%0d", d, cyc), int'(dut_done[d]), int'(m_done[d]));
        end
      end
    end
  end

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
    tb_delay = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    // Mode 0 and 1 sequence, delays {3,1,0,2}
    set_delays(3, 1, 0, 2);
    do_reset(2);
    #1; chk("A c0 start m0", int'(dut_start[0]), 0); chk("A c0 done m0", int'(dut_done[0]), 0);
    chk("A c0 tick m0", int'(dut_tick[0]), 0);
    goto(4);  #1; chk("A c4 tick", int'(dut_tick[0]), 1);
    goto(5);  #1; chk("A c5 start m0", int'(dut_start[0]), 4'b0010); chk("A c5 start m1", int'(dut_start[1]), 4'b0010);
    goto(6);  #1; chk("A c6 start m1", int'(dut_start[1]), 0);
    goto(8);  #1; chk("A c8 tick", int'(dut_tick[0]), 1);
    goto(9);  #1; chk("A c9 start m0", int'(dut_start[0]), 4'b1010); chk("A c9 start m1", int'(dut_start[1]), 4'b1000);
    goto(12); #1; chk("A c12 tick", int'(dut_tick[0]), 1); chk("A c12 done m0", int'(dut_done[0]), 0);
    goto(13); #1; chk("A c13 start m0", int'(dut_start[0]), 4'b1011); chk("A c13 done m0", int'(dut_done[0]), 1);
    chk("A c13 start m1", int'(dut_start[1]), 4'b0001); chk("A c13 done m1", int'(dut_done[1]), 1);
    goto(14); #1; chk("A c14 start m1", int'(dut_start[1]), 0); chk("A c14 done m1", int'(dut_done[1]), 1);
    goto(16); #1; chk("A c16 tick stopped", int'(dut_tick[0]), 0); chk("A c16 start m0", int'(dut_start[0]), 4'b1011);

    // Restart from DONE with new delays {1}
    goto(20); tb_restart = 1'b1; set_delays(1, 0, 0, 0);
    goto(21); tb_restart = 1'b0; cyc = 0;
    #1; chk("R load start m0", int'(dut_start[0]), 0); chk("R load done m0", int'(dut_done[0]), 0);
    goto(4);  #1; chk("R c4 start m0", int'(dut_start[0]), 0);
    goto(5);  #1; chk("R c5 start m0", int'(dut_start[0]), 1); chk("R c5 done m0", int'(dut_done[0]), 1);

    // Periodic mode, delays {2,3}
    set_delays(2, 3, 0, 0);
    do_reset(2);
    goto(9);  #1; chk("B c9 start m2", int'(dut_start[2]), 4'b0001);
    goto(12); #1; chk("B c12 done m2", int'(dut_done[2]), 0);
    goto(13); #1; chk("B c13 start m2", int'(dut_start[2]), 4'b0010); chk("B c13 done m2", int'(dut_done[2]), 1);
    goto(14); #1; chk("B c14 start m2", int'(dut_start[2]), 0);
    goto(17); #1; chk("B c17 start m2", int'(dut_start[2]), 4'b0001);
    goto(25); #1; chk("B c25 start m2", int'(dut_start[2]), 4'b0011);
    goto(28); #1; chk("B c28 tick m2", int'(dut_tick[2]), 1); chk("B c28 done m2", int'(dut_done[2]), 1);

    // Hold for cycles 6..10, delay {3}
    set_delays(3, 0, 0, 0);
    do_reset(2);
    goto(6);  tb_hold = 1'b1;
    goto(8);  #1; chk("C c8 tick held", int'(dut_tick[0]), 0);
    goto(11); tb_hold = 1'b0;
    goto(13); #1; chk("C c13 start m0", int'(dut_start[0]), 0); chk("C c13 tick", int'(dut_tick[0]), 1);
    goto(17); #1; chk("C c17 start m0", int'(dut_start[0]), 0);
    goto(18); #1; chk("C c18 start m0", int'(dut_start[0]), 1);

    // Reset mid-run in cycle 7
    set_delays(3, 1, 0, 2);
    do_reset(2);
    goto(7);  rst = 1'b1;
    goto(8);  rst = 1'b0; cyc = 0;
    #1; chk("D rst start m0", int'(dut_start[0]), 0); chk("D rst done m0", int'(dut_done[0]), 0);
    chk("D rst tick m0", int'(dut_tick[0]), 0);
    goto(5);  #1; chk("D c5 start m0", int'(dut_start[0]), 4'b0010);
    goto(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/common_timer_seq.md
Name: common_timer_seq

Overview:
Multi-channel, parametrised successor to the single power-up start timer. A shared prescaler generates a programmable time base. NUM_CH independent channel counters each assert a start strobe after their own delay, counted in ticks. The block sequences bring-up of sensor, DDR, HDMI and DMA sub-blocks after configuration, and supports level, single-pulse and periodic modes, plus hold and restart controls.

Parameters:
MHZ, 50, clk frequency in MHz.
TICK_US, 1000, tick period in microseconds. TICK_CYC = MHZ*TICK_US; TICK_CYC must be at least 2.
NUM_CH, 4, number of channels (1..16).
CNT_W, 16, width of each channel delay and counter.
MODE, 0, output mode: 0 = sticky level, 1 = single one-cycle pulse, 2 = periodic one-cycle pulse.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
i_restart  input  1  synchronous restart of all channels; re-latches delays.
i_hold  input  1  freezes prescaler and channel counters while high.
i_delay  input  NUM_CH*CNT_W  per-channel delay in ticks; channel k occupies bits [k*CNT_W +: CNT_W].
o_tick  output  1  one-cycle time-base tick.
o_start  output  NUM_CH  per-channel start strobes or levels.
o_done  output  1  sticky; all enabled channels have fired at least once.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. When rst=1, all registers clear: o_start=0, o_done=0, o_tick=0, prescaler=0, FSM=LOAD.
- FSM states: LOAD, RUN, DONE.
  - LOAD lasts exactly one cycle. It latches i_delay into dly_k and cnt_k, clears fired_k, and holds the prescaler at 0. It then goes to RUN.
  - RUN goes to DONE when every enabled channel's fired_k=1, in modes 0 and 1 only.
  - In mode 2 the FSM stays in RUN; o_done still asserts once all enabled channels have fired once.
  - DONE stops the prescaler. o_tick=0. Outputs hold their mode-defined values.
- Prescaler (width clog2(TICK_CYC)):
  - Counts 0..TICK_CYC-1 in RUN while i_hold=0, then wraps to 0.
  - o_tick = (prescaler==TICK_CYC-1) && RUN && !i_hold. It is decoded from registered state.
- Channel k when dly_k==0: channel is disabled. It never fires and is treated as fired for o_done.
- Channel k on a tick, with cnt_k != 0: cnt_k decrements.
  - When cnt_k==1 at a tick, this is a fire event: fired_k <= 1.
  - Mode 2 reloads cnt_k <= dly_k on the same edge.
- o_start[k] is registered and rises the cycle after the fire tick.
  - Mode 0: stays high until rst or i_restart.
  - Mode 1: high for exactly one cycle.
  - Mode 2: high for one cycle on every fire event.
- Latency: cycle 0 is the first edge sampling rst=0 (the LOAD cycle). o_start[k] is first high in cycle 1 + dly_k*TICK_CYC. o_done rises in the same cycle as the last enabled o_start rises.
- Simultaneous fires: channels with equal delays assert o_start in the same cycle.
- i_hold:
  - Freezes the prescaler and cnt_k.
  - A pulse already registered still completes its single cycle.
  - Mode 0 levels stay high.
  - Hold in LOAD is ignored.
- i_restart:
  - Forces o_start=0, o_done=0 and prescaler=0, then goes to LOAD on the next edge.
  - Restart beats hold; rst beats restart.
  - Restart in DONE is allowed and re-arms all channels.
- i_delay changes outside LOAD are ignored. Mode 2 reloads use the latched dly_k.
- Counter width: cnt_k never underflows. The maximum delay is 2^CNT_W - 1 ticks.

Test Plan:
- MHZ=4, TICK_US=1 (TICK_CYC=4), MODE=0, delays {3,1,0,2}, release rst. Required:
  - o_tick in cycles 4, 8, 12.
  - o_start[1] high from cycle 5, o_start[3] from cycle 9, o_start[0] from cycle 13.
  - o_start[2] never high.
  - o_done rises in cycle 13; o_tick stops after that.
- Same configuration with MODE=1 -> each enabled o_start is high for exactly one cycle (cycles 5, 9, 13). o_done is sticky from cycle 13.
- MODE=2, delays {2,3}:
  - o_start[0] pulses in cycles 9, 17, 25.
  - o_start[1] pulses in cycles 13, 25.
  - o_done rises in cycle 13; the prescaler keeps running.
- MODE=0, delays {3}, i_hold high for 5 cycles starting at cycle 6 -> o_start[0] rises in cycle 18, not 13. o_tick stays 0 during hold.
- MODE=0, all channels fired, then pulse i_restart for one cycle with new delays {1} -> o_start and o_done clear on the next edge, LOAD follows, and o_start[0] rises 5 cycles after LOAD.
- Assert rst mid-RUN in cycle 7 -> all outputs are 0 on the next edge. The sequence then restarts from cycle 0 with the current i_delay.
